// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned ADD3_THRESH = 5;

    // Decimal digits needed to hold 2^w - 1 without truncation.
    function automatic int unsigned min_digits(input int unsigned w);
        logic [63:0] v;
        int unsigned d;
        v = (64'd1 << w) - 64'd1;
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One shift-and-add-3 step over an NDIG-digit BCD accumulator.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 3
) (
    input  logic [4*NDIG-1:0] acc,
    input  logic              shift_in,
    output logic [4*NDIG-1:0] acc_next,
    output logic              carry_out
);

    localparam int unsigned BW = 4 * NDIG;

    logic [BW-1:0] adj;

    // Per-nibble +3, no carry between nibbles; a digit <= 9 becomes at most 12.
    always_comb begin
        adj = acc;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (acc[4*i +: 4] >= 4'(ADD3_THRESH)) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign acc_next  = {adj[BW-2:0], shift_in};
    assign carry_out = adj[BW-1];

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, valid/ready on both sides.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned NDIG   = 3,
    parameter int unsigned SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      bin_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] bcd_out,
    output logic              sign_out,
    output logic              ovf,
    output logic              busy
);

    localparam int unsigned BW = 4 * NDIG;
    localparam int unsigned CW = $clog2(W + 1);

    state_e        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [BW-1:0] acc_q, acc_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sign_q, sign_d;
    logic          sign_out_q, sign_out_d;
    logic          ovf_acc_q, ovf_acc_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    logic          accept_c;
    logic          last_c;
    logic          neg_c;
    logic [W-1:0]  mag_c;
    logic [BW-1:0] step_acc;
    logic          step_carry;

    bcd_dabble_step #(.NDIG(NDIG)) u_step (
        .acc       (acc_q),
        .shift_in  (shreg_q[W-1]),
        .acc_next  (step_acc),
        .carry_out (step_carry)
    );

    // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
    assign neg_c    = (SIGNED != 0) && bin_in[W-1];
    assign mag_c    = neg_c ? (~bin_in + 1'b1) : bin_in;
    assign accept_c = in_valid && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign last_c   = (state_q == ST_CONV) && (cnt_q == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_CONV;
            ST_CONV: if (last_c) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = in_valid ? ST_CONV : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        sign_out_d  = sign_out_q;
        ovf_acc_d   = ovf_acc_q;
        ovf_d       = ovf_q;
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_CONV);
        in_ready    = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        if (accept_c) begin
            shreg_d   = mag_c;
            sign_d    = neg_c;
            acc_d     = '0;
            ovf_acc_d = 1'b0;
            cnt_d     = '0;
        end else if (state_q == ST_CONV) begin
            shreg_d   = shreg_q << 1;
            acc_d     = step_acc;
            cnt_d     = cnt_q + 1'b1;
            ovf_acc_d = ovf_acc_q | step_carry;
            // Results only reach the outputs once the last step completes.
            if (last_c) begin
                bcd_d      = step_acc;
                ovf_d      = ovf_acc_q | step_carry;
                sign_out_d = sign_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            acc_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            sign_out_q  <= 1'b0;
            ovf_acc_q   <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            sign_out_q  <= sign_out_d;
            ovf_acc_q   <= ovf_acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign sign_out  = sign_out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
